// File: rtl/staged_data_reg.sv
// staged_data_reg: DEPTH-stage enable-gated delay line for WIDTH-bit words with valid tracking,
// synchronous flush, registered occupancy count and an optional hold-last-valid output register.
`default_nettype none

module staged_data_reg #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      DEPTH      = 2,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter bit               HOLD_VALID = 1'b0
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         en,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             dataIn,
   input  logic                         validIn,
   output logic [WIDTH-1:0]             dataOut,
   output logic                         validOut,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned           CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [WIDTH-1:0] data_d  [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Stage shift and occupancy update; flush wins over en and drops dataIn.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;
      if (flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = RESET_VAL;
         end
         valid_d = '0;
         count_d = '0;
      end else if (en) begin
         data_d[0]  = dataIn;
         valid_d[0] = validIn;
         for (int k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         count_d = count_q + CNT_W'(validIn) - CNT_W'(valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= RESET_VAL;
         end
         valid_q <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign validOut = valid_q[DEPTH-1];
   assign count    = count_q;

   generate
      if (HOLD_VALID) begin : g_hold
         logic [WIDTH-1:0] last_in_data;
         logic             last_in_valid;
         logic [WIDTH-1:0] hold_q;
         logic [WIDTH-1:0] hold_d;

         // The word about to enter the last stage decides whether the hold register reloads.
         if (DEPTH == 1) begin : g_in_d1
            assign last_in_data  = dataIn;
            assign last_in_valid = validIn;
         end else begin : g_in_dn
            assign last_in_data  = data_q[DEPTH-2];
            assign last_in_valid = valid_q[DEPTH-2];
         end

         always_comb begin
            hold_d = hold_q;
            if (flush) begin
               hold_d = RESET_VAL;
            end else if (en && last_in_valid) begin
               hold_d = last_in_data;
            end
         end

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               hold_q <= RESET_VAL;
            end else begin
               hold_q <= hold_d;
            end
         end

         assign dataOut = hold_q;
      end else begin : g_follow
         assign dataOut = data_q[DEPTH-1];
      end
   endgenerate

`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (RST) begin
         assert (count_q <= DEPTH_C)
            else $error("staged_data_reg: count %0d exceeds DEPTH %0d", count_q, DEPTH);
         assert (count_q == CNT_W'($countones(valid_q)))
            else $error("staged_data_reg: count %0d disagrees with valid bits %b", count_q, valid_q);
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/staged_data_reg.md
Name: staged_data_reg

Overview:
- Parametrised successor to the single-stage multicycle-CPU data latch; shares that latch's CLK naming and dataIn/dataOut convention.
- Delays a WIDTH-bit data word through DEPTH enable-gated register stages, each with a valid bit.
- Supports synchronous flush, an occupancy count, and an optional hold-last-valid output mode.
- Sits between the datapath register file/ALU/memory and the next multicycle phase, wherever a value must survive stalls for more than one state.

Parameters:
- WIDTH, 32, data word width in bits (1..64).
- DEPTH, 2, number of register stages (1..8).
- RESET_VAL, 0, value loaded into every data stage and the output register on reset or flush (WIDTH bits).
- HOLD_VALID, 0, 0 = dataOut follows the last stage; 1 = dataOut keeps the last valid word leaving the last stage.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous active-low reset; asserted when 0.
- en  input  1  advance; all stages shift when 1, all hold when 0.
- flush  input  1  synchronous clear of all stages; overrides en.
- dataIn  input  WIDTH  word captured into stage 0.
- validIn  input  1  qualifies dataIn.
- dataOut  output  WIDTH  delayed word (mode-dependent, see Behaviour).
- validOut  output  1  valid bit of the last stage.
- count  output  clog2(DEPTH+1)  number of stages currently holding valid data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- RST=0 forces immediately, independent of CLK:
  - every stage data = RESET_VAL and every stage valid = 0;
  - dataOut = RESET_VAL, validOut = 0, count = 0.
- Release of RST takes effect at the next posedge.
- Priority per posedge: RST, then flush, then en.
- flush=1:
  - all stage data = RESET_VAL, all valid = 0, count = 0;
  - in HOLD_VALID=1 the hold register is also cleared to RESET_VAL;
  - dataIn is dropped even if en=1.
- en=1, flush=0:
  - stage0 <= {dataIn, validIn};
  - stage k <= stage k-1 for k = 1..DEPTH-1.
  - Invalid words shift like valid ones; data of invalid stages is don't-care but must not alter dataOut in HOLD_VALID=1.
- en=0, flush=0: every register holds, including count and the hold register.
- Latency: a word presented with en=1 reaches the last stage after exactly DEPTH en=1 edges. en=0 cycles stretch latency by the same number of cycles. No combinational path from dataIn to dataOut.
- DEPTH=1: a single enabled register. With en tied 1, flush 0 and HOLD_VALID=0, dataOut equals the one-stage latch behaviour.
- HOLD_VALID=0: dataOut = last-stage data, registered.
- HOLD_VALID=1: dataOut is a separate register loaded on an en=1 edge only when the word entering the last stage is valid; otherwise it holds. validOut still reports the last-stage valid bit.
- count is maintained as a register, not recomputed by popcount:
  - on an en edge: count_next = count + validIn - (valid bit shifted out of the last stage);
  - validIn=1 and shift-out valid in the same edge leaves count unchanged.
- count never exceeds DEPTH and never underflows; an assertion in RTL flags violations in simulation.
- Reset asserted mid-operation discards all in-flight words; no partial shift is permitted.

Test Plan:
- Reset: RST=0 with dataIn=32'hDEADBEEF, validIn=1, en=1 for 3 cycles → dataOut=0, validOut=0, count=0 throughout. Asynchronous clear is checked by asserting RST between edges.
- Latency: DEPTH=2, HOLD_VALID=0, en=1. Drive 32'h11, 32'h22, 32'h33 valid on consecutive edges → dataOut=32'h11 after edge 2, 32'h22 after edge 3, 32'h33 after edge 4. count goes 1, 2, 2, then decrements to 0 once validIn=0.
- Stall: DEPTH=3, load 32'hA5 valid, then en=0 for 5 cycles → all outputs frozen. 32'hA5 appears at dataOut 3 en-edges after entry, i.e. 8 clocks total.
- Flush priority: DEPTH=2, two valid words in flight, assert flush=1 with en=1 and dataIn=32'h77 valid → next edge dataOut=RESET_VAL, validOut=0, count=0. 32'h77 never appears.
- Hold mode: HOLD_VALID=1, DEPTH=2. Send 32'hCAFE valid followed by invalid words → dataOut stays 32'hCAFE while validOut drops to 0. A following valid 32'hBEEF replaces it exactly 2 en-edges after entry.
- DEPTH=1 sweep with random dataIn, en=1, flush=0: dataOut(t+1) = dataIn(t) for 1000 cycles. count toggles 0/1 matching validIn of the previous edge.
